// File: rtl/score_scan.sv
// Four-digit BCD score counter with saturation, plus a multiplexed scan driver
// that shows a per-frame snapshot of the score on digits 3..0 with leading-zero blanking.
module score_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clear,
  input  logic        blank_en,
  output logic [3:0]  number,
  output logic [7:0]  AN,
  output logic [15:0] score,
  output logic        sat
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // Decimal increment that holds at 9999; any nibble at or above 9 rolls to 0.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] >= 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Position k blanks when it and every more significant nibble are zero; digit 0 never blanks.
  function automatic logic digit_blank(input logic [15:0] s, input logic [1:0] k);
    return (k != 2'd0) && ((s >> {k, 2'b00}) == 16'h0000);
  endfunction

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tick;
  logic [1:0]       idx, idx_nxt;
  logic [15:0]      snap, snap_nxt;
  logic [15:0]      score_nxt;
  logic [3:0]       an_lo;
  logic [7:0]       an_nxt;

  always_comb begin
    tick      = (cnt == CNT_MAX);
    cnt_nxt   = tick ? '0 : cnt + 1'b1;
    score_nxt = score;
    if (clear)
      score_nxt = 16'h0000;
    else if (inc)
      score_nxt = bcd_inc_sat(score);
    idx_nxt  = idx + 2'd1;
    snap_nxt = (idx == 2'd3) ? score : snap;
    an_lo    = ~(4'b0001 << idx_nxt);
    if (blank_en && digit_blank(snap_nxt, idx_nxt))
      an_lo = 4'hF;
    an_nxt = {4'hF, an_lo};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      score  <= 16'h0000;
      sat    <= 1'b0;
      idx    <= 2'd0;
      snap   <= 16'h0000;
      number <= 4'h0;
      AN     <= 8'b1111_1110;
    end else begin
      cnt   <= cnt_nxt;
      score <= score_nxt;
      sat   <= (score_nxt == 16'h9999);
      // Scan outputs move together on the slot boundary so number and AN never disagree.
      if (tick) begin
        idx    <= idx_nxt;
        snap   <= snap_nxt;
        number <= snap_nxt[{idx_nxt, 2'b00} +: 4];
        AN     <= an_nxt;
      end
    end
  end

endmodule

// File: tb/tb_score_scan.sv
// Randomized scoreboard bench for score_scan with REFRESH_DIV=4, using a decimal reference model.
module tb_score_scan;

  localparam int DIV = 4;

  logic        clk;
  logic        rst_n;
  logic        inc;
  logic        clear;
  logic        blank_en;
  logic [3:0]  number;
  logic [7:0]  AN;
  logic [15:0] score;
  logic        sat;

  score_scan #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc),
    .clear    (clear),
    .blank_en (blank_en),
    .number   (number),
    .AN       (AN),
    .score    (score),
    .sat      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] score;
    logic        sat;
    logic [3:0]  number;
    logic [7:0]  an;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state: plain integers, the score is an ordinary decimal number.
  int m_sc, m_cnt, m_idx, m_snap, m_num, m_an;
  int pw[4] = '{1, 10, 100, 1000};

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int d = 0; d < 4; d++) r[4*d +: 4] = 4'((v / pw[d]) % 10);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_sc = 0; m_cnt = 0; m_idx = 0; m_snap = 0; m_num = 0; m_an = 8'hFE;
  endtask

  task automatic model_edge(input bit i, input bit c, input bit b);
    bit  tk;
    bit  blk;
    int  old;
    exp_t e;
    tk    = (m_cnt == DIV - 1);
    m_cnt = (m_cnt + 1) % DIV;
    old   = m_sc;
    if (c) m_sc = 0;
    else if (i && m_sc < 9999) m_sc = m_sc + 1;
    if (tk) begin
      if (m_idx == 3) m_snap = old;
      m_idx = (m_idx + 1) % 4;
      m_num = (m_snap / pw[m_idx]) % 10;
      blk   = b && (m_idx > 0) && (m_snap < pw[m_idx]);
      m_an  = blk ? 255 : 255 - (1 << m_idx);
    end
    e.score  = to_bcd(m_sc);
    e.sat    = (m_sc == 9999);
    e.number = 4'(m_num);
    e.an     = 8'(m_an);
    q.push_back(e);
  endtask

  task automatic step(input bit i, input bit c, input bit b);
    inc = i; clear = c; blank_en = b;
    @(posedge clk);
    model_edge(i, c, b);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_score"},  32'(score),  32'h0000);
    chk({tag, "_sat"},    32'(sat),    32'h0);
    chk({tag, "_number"}, 32'(number), 32'h0);
    chk({tag, "_an"},     32'(AN),     32'hFE);
  endtask

  // Monitor: compares every registered output against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("score",  32'(score),  32'(e.score));
      chk("sat",    32'(sat),    32'(e.sat));
      chk("number", 32'(number), 32'(e.number));
      chk("an",     32'(AN),     32'(e.an));
    end
  end

  initial begin
    rst_n = 1'b1; inc = 1'b0; clear = 1'b0; blank_en = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_values("rst0");
    model_reset();
    #19 rst_n = 1'b1;

    // Idle scan: AN walks FE,FD,FB,F7 with 4 cycles per slot.
    repeat (16) step(1'b0, 1'b0, 1'b0);

    // 0009 -> 0010, then let the snapshot catch up.
    repeat (9) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b1);

    // Random traffic with occasional clears and blank_en toggling.
    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 3) != 0));

    // Saturation from 0000, inc held past 9999, then clear.
    step(1'b0, 1'b1, 1'b0);
    repeat (10050) step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Clear wins over simultaneous inc at 0042.
    repeat (42) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // 0050 with blanking on, then off.
    repeat (50) step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b1);
    repeat (16) step(1'b0, 1'b0, 1'b0);

    // Reach 1234 and idx=2, then pulse reset between clock edges.
    step(1'b0, 1'b1, 1'b0);
    repeat (1234) step(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 40 && m_idx != 2; n++) step(1'b0, 1'b0, 1'b0);
    chk("pre_reset_idx", 32'(m_idx), 32'd2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values("rst_mid");
    model_reset();
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) step(1'b0, 1'b0, 1'b1);
    repeat (30) step(1'b1, 1'b0, 1'b1);

    inc = 1'b0; clear = 1'b0;
    for (int n = 0; n < 10 && q.size() > 0; n++) @(posedge clk);
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain actual=%0d required=0 pending expectations", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
